tlb_command_arbiter: RTL and testbench
======================================

# tlb_command_arbiter

Shares a single `tlb` instance between the pipeline's per-cycle lookup stream and queued maintenance commands (update, invalidate, invalidate-all) from the control register path. It guarantees that at most one TLB command is asserted per cycle and spaces maintenance commands to respect the TLB's two-stage write. It also bounds maintenance starvation by stalling lookups, and reports commit of each maintenance command. It sits between the instruction/data cache tag stage and the `tlb` command port.

## Interface
Parameters:
- CMD_FIFO_DEPTH, 4, maintenance command queue entries (power of two, ≥2)
- MAX_WAIT, 8, cycles a queued command may be blocked by lookups before lookups are stalled (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lookup_req  in  1  pipeline requests a lookup this cycle
- lookup_vpage_idx  in  page_index_t  lookup virtual page
- lookup_asid  in  ASID_WIDTH  lookup address space
- lookup_stall  out  1  lookup not issued this cycle; pipeline holds request
- lookup_valid  out  1  TLB response outputs valid this cycle for the lookup granted last cycle
- cmd_valid / cmd_ready  in / out  1  maintenance enqueue handshake
- cmd_op  in  2  0 update, 1 invalidate, 2 invalidate-all, 3 reserved (dropped, still signals done)
- cmd_vpage_idx, cmd_asid, cmd_ppage_idx  in  page_index_t / ASID_WIDTH / page_index_t  command fields
- cmd_present, cmd_exe_writable, cmd_supervisor, cmd_global  in  1 each  update attributes
- cmd_done  out  1  one-cycle pulse: oldest issued command has committed
- cmd_pending  out  1  queue non-empty or command in flight
- tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en  out  1 each  TLB commands, onehot0
- tlb_request_vpage_idx, tlb_request_asid, tlb_update_ppage_idx  out  TLB operands
- tlb_update_present, tlb_update_exe_writable, tlb_update_supervisor, tlb_update_global  out  1 each

## Operation
- Queue: FIFO of CMD_FIFO_DEPTH. Enqueue when cmd_valid && cmd_ready. cmd_ready = !full. Commands are issued and completed strictly in order.
- Per-cycle grant, in priority order:
  1. Starvation. If wait_count == MAX_WAIT and the head is issuable, issue the head and assert lookup_stall.
  2. Lookup. If lookup_req, issue the lookup with tlb_lookup_en=1 and operands from the lookup_* inputs.
  3. Maintenance. Otherwise, if the head is issuable, issue it.
- Issuable means the queue is non-empty and the previous cycle did not issue a maintenance command (mandatory one-cycle bubble between maintenance commands).
- Issuing a maintenance command asserts exactly the en matching cmd_op, drives the operands from the head entry, and pops the head. op 3 asserts no en.
- wait_count:
  - Increments each cycle the head is issuable but loses to a lookup.
  - Resets to 0 on every maintenance issue.
  - Saturates at MAX_WAIT.
  - Holds during bubble cycles.
- lookup_stall = lookup_req && a maintenance command is issued this cycle.
- Operand outputs when no en is asserted: don't-care. They are driven from the lookup inputs to avoid extra muxing.
- Reserved op: behaves as an issued maintenance command with no TLB effect. It consumes its slot and the bubble, and produces cmd_done.

## Timing
- Lookup granted in cycle N: lookup_valid=1 in N+1, aligned with the TLB lookup_hit/ppage outputs.
- Maintenance issued in cycle N: the TLB write commits at the end of N+1; cmd_done=1 in N+1. The same holds for invalidate-all and reserved ops.
- Bubble: after maintenance in N, the earliest next maintenance issue is N+2. A lookup may issue in N+1. The TLB's read-during-write and valid bypass keep a lookup in N+1 coherent with the N+1 commit.
- Enqueue in cycle N: the entry is earliest issuable in N+1 (no same-cycle bypass).
- Simultaneous enqueue and issue with queue full: cmd_ready was 0, so there is no enqueue. The slot frees for cmd_ready in N+1.
- Reset values:
  - All tlb_*_en = 0
  - lookup_stall = 0, lookup_valid = 0, cmd_done = 0, cmd_pending = 0
  - cmd_ready = 1
  - Queue empty, wait_count = 0, bubble flag clear
- Reset mid-operation: the queue is discarded and in-flight completion pulses are suppressed. A TLB write already committing at the reset edge is not tracked.
- Invariant (assert): tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en are onehot0 every cycle.

## Test plan
- **Idle lookup.** Enqueue nothing; lookup_req=1 for 5 cycles with vpage 0x12345 → tlb_lookup_en=1 for 5 cycles, lookup_valid=1 cycles 2-6, lookup_stall=0 throughout.
- **Update then lookup.** Enqueue update vpage 0x00040, ppage 0x00777, with lookup_req=0. The update issues at N → cmd_done at N+1. A lookup of 0x00040 at N+1 → hit with ppage 0x00777 at N+2.
- **Bubble.** Enqueue 3 updates back-to-back with lookup_req=0 → tlb_update_en in cycles N, N+2, N+4; cmd_done in N+1, N+3, N+5; cmd_pending falls after N+5.
- **Starvation, MAX_WAIT=8.** Enqueue one invalidate; lookup_req held at 1 → 8 lookup grants, then 1 cycle with tlb_invalidate_en=1 and lookup_stall=1, then lookups resume.
- **Full queue.** Enqueue 4 commands while lookup_req=1 (none issue for the first 8 cycles) → cmd_ready=0 after the 4th. The first issue reasserts cmd_ready the next cycle.
- **Reset and reserved op.**
  - Reset asserted with 2 queued commands → no tlb_*_en or cmd_done afterwards; cmd_ready=1.
  - cmd_op=3 → no en asserted; cmd_done pulses one cycle after issue.

Source files
------------

// File: rtl/tlb_command_arbiter.sv
// tlb_command_arbiter: shares one TLB command port between the per-cycle
// lookup stream and an in-order queue of maintenance commands (update,
// invalidate, invalidate-all, reserved). Maintenance commands are spaced by
// a one-cycle bubble for the TLB's two-stage write. A queued command that
// keeps losing to lookups for MAX_WAIT cycles forces a lookup stall.
module tlb_command_arbiter #(
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int MAX_WAIT       = 8,
  parameter int PAGE_W         = 20,
  parameter int ASID_WIDTH     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_req,
  input  logic [PAGE_W-1:0]     lookup_vpage_idx,
  input  logic [ASID_WIDTH-1:0] lookup_asid,
  output logic                  lookup_stall,
  output logic                  lookup_valid,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [PAGE_W-1:0]     cmd_vpage_idx,
  input  logic [ASID_WIDTH-1:0] cmd_asid,
  input  logic [PAGE_W-1:0]     cmd_ppage_idx,
  input  logic                  cmd_present,
  input  logic                  cmd_exe_writable,
  input  logic                  cmd_supervisor,
  input  logic                  cmd_global,
  output logic                  cmd_done,
  output logic                  cmd_pending,
  output logic                  tlb_lookup_en,
  output logic                  tlb_update_en,
  output logic                  tlb_invalidate_en,
  output logic                  tlb_invalidate_all_en,
  output logic [PAGE_W-1:0]     tlb_request_vpage_idx,
  output logic [ASID_WIDTH-1:0] tlb_request_asid,
  output logic [PAGE_W-1:0]     tlb_update_ppage_idx,
  output logic                  tlb_update_present,
  output logic                  tlb_update_exe_writable,
  output logic                  tlb_update_supervisor,
  output logic                  tlb_update_global
);

  localparam int PTR_W  = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] OP_UPDATE   = 2'd0;
  localparam logic [1:0] OP_INVAL    = 2'd1;
  localparam logic [1:0] OP_INVAL_ALL = 2'd2;

  // Queue storage (data only, never reset) and control state.
  logic [1:0]            r_q_op    [CMD_FIFO_DEPTH];
  logic [PAGE_W-1:0]     r_q_vpage [CMD_FIFO_DEPTH];
  logic [ASID_WIDTH-1:0] r_q_asid  [CMD_FIFO_DEPTH];
  logic [PAGE_W-1:0]     r_q_ppage [CMD_FIFO_DEPTH];
  logic [3:0]            r_q_attr  [CMD_FIFO_DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait;
  logic              r_bubble;
  logic              r_done;
  logic              r_lookup_valid;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_issuable;
  logic              w_starve;
  logic              w_issue_maint;
  logic              w_issue_lookup;
  logic [1:0]        w_head_op;
  logic [3:0]        w_head_attr;

  assign w_full         = (r_count == CNT_W'(CMD_FIFO_DEPTH));
  assign w_empty        = (r_count == '0);
  assign w_push         = cmd_valid && !w_full;
  assign w_issuable     = !w_empty && !r_bubble;
  assign w_starve       = w_issuable && (r_wait == WAIT_W'(MAX_WAIT));
  assign w_issue_maint  = w_starve || (w_issuable && !lookup_req);
  assign w_issue_lookup = lookup_req && !w_starve;
  assign w_head_op      = r_q_op[r_rd_ptr];
  assign w_head_attr    = r_q_attr[r_rd_ptr];

  // Drive the TLB command and operands from the winner of this cycle's grant.
  always_comb begin
    tlb_lookup_en           = w_issue_lookup;
    tlb_update_en           = 1'b0;
    tlb_invalidate_en       = 1'b0;
    tlb_invalidate_all_en   = 1'b0;
    tlb_request_vpage_idx   = lookup_vpage_idx;
    tlb_request_asid        = lookup_asid;
    tlb_update_ppage_idx    = r_q_ppage[r_rd_ptr];
    tlb_update_present      = w_head_attr[3];
    tlb_update_exe_writable = w_head_attr[2];
    tlb_update_supervisor   = w_head_attr[1];
    tlb_update_global       = w_head_attr[0];
    if (w_issue_maint) begin
      tlb_request_vpage_idx = r_q_vpage[r_rd_ptr];
      tlb_request_asid      = r_q_asid[r_rd_ptr];
      tlb_update_en         = (w_head_op == OP_UPDATE);
      tlb_invalidate_en     = (w_head_op == OP_INVAL);
      tlb_invalidate_all_en = (w_head_op == OP_INVAL_ALL);
    end
    lookup_stall = lookup_req && w_issue_maint;
    lookup_valid = r_lookup_valid;
    cmd_done     = r_done;
    cmd_pending  = !w_empty || r_done;
    cmd_ready    = !w_full;
  end

  // Capture an accepted command into the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_op[r_wr_ptr]    <= cmd_op;
      r_q_vpage[r_wr_ptr] <= cmd_vpage_idx;
      r_q_asid[r_wr_ptr]  <= cmd_asid;
      r_q_ppage[r_wr_ptr] <= cmd_ppage_idx;
      r_q_attr[r_wr_ptr]  <= {cmd_present, cmd_exe_writable, cmd_supervisor, cmd_global};
    end
  end

  // Queue pointers, starvation counter, bubble and completion tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_wait         <= '0;
      r_bubble       <= 1'b0;
      r_done         <= 1'b0;
      r_lookup_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_issue_maint) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_issue_maint})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A head that loses to a lookup ages; bubble cycles leave it untouched.
      if (w_issue_maint) r_wait <= '0;
      else if (w_issuable && lookup_req && (r_wait != WAIT_W'(MAX_WAIT)))
        r_wait <= r_wait + WAIT_W'(1);
      r_bubble       <= w_issue_maint;
      r_done         <= w_issue_maint;
      r_lookup_valid <= w_issue_lookup;
    end
  end

  a_cmd_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0({tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}));

endmodule

// File: tb/tb_tlb_command_arbiter.sv
// Bench for tlb_command_arbiter: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_tlb_command_arbiter;

  localparam int DEPTH  = 4;
  localparam int MAXW   = 8;
  localparam int PW     = 20;
  localparam int AW     = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lookup_req = 1'b0;
  logic [PW-1:0] lookup_vpage_idx = '0;
  logic [AW-1:0] lookup_asid = '0;
  logic lookup_stall, lookup_valid;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [PW-1:0] cmd_vpage_idx = '0;
  logic [AW-1:0] cmd_asid = '0;
  logic [PW-1:0] cmd_ppage_idx = '0;
  logic cmd_present = 1'b0, cmd_exe_writable = 1'b0, cmd_supervisor = 1'b0, cmd_global = 1'b0;
  logic cmd_done, cmd_pending;
  logic tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en;
  logic [PW-1:0] tlb_request_vpage_idx;
  logic [AW-1:0] tlb_request_asid;
  logic [PW-1:0] tlb_update_ppage_idx;
  logic tlb_update_present, tlb_update_exe_writable, tlb_update_supervisor, tlb_update_global;

  tlb_command_arbiter #(.CMD_FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW), .PAGE_W(PW), .ASID_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .lookup_req(lookup_req), .lookup_vpage_idx(lookup_vpage_idx), .lookup_asid(lookup_asid),
    .lookup_stall(lookup_stall), .lookup_valid(lookup_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_vpage_idx(cmd_vpage_idx), .cmd_asid(cmd_asid), .cmd_ppage_idx(cmd_ppage_idx),
    .cmd_present(cmd_present), .cmd_exe_writable(cmd_exe_writable),
    .cmd_supervisor(cmd_supervisor), .cmd_global(cmd_global),
    .cmd_done(cmd_done), .cmd_pending(cmd_pending),
    .tlb_lookup_en(tlb_lookup_en), .tlb_update_en(tlb_update_en),
    .tlb_invalidate_en(tlb_invalidate_en), .tlb_invalidate_all_en(tlb_invalidate_all_en),
    .tlb_request_vpage_idx(tlb_request_vpage_idx), .tlb_request_asid(tlb_request_asid),
    .tlb_update_ppage_idx(tlb_update_ppage_idx),
    .tlb_update_present(tlb_update_present), .tlb_update_exe_writable(tlb_update_exe_writable),
    .tlb_update_supervisor(tlb_update_supervisor), .tlb_update_global(tlb_update_global)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    op;
    logic [PW-1:0] vp;
    logic [AW-1:0] asid;
    logic [PW-1:0] pp;
    logic [3:0]    attr;
  } cmd_t;

  cmd_t mq[$];
  bit   m_bubble = 0;
  int   m_wait = 0;
  bit   m_lv = 0;
  bit   m_done = 0;
  bit   e_iss = 0, e_starve = 0, e_maint = 0, e_lookup = 0;
  cmd_t h;

  // Expected outputs for the current cycle, compared on the falling edge.
  always @(negedge clk) begin
    e_iss    = (mq.size() > 0) && !m_bubble;
    e_starve = e_iss && (m_wait >= MAXW);
    e_maint  = e_starve || (e_iss && !lookup_req);
    e_lookup = lookup_req && !e_starve;
    h = (mq.size() > 0) ? mq[0] : '0;
    if (!reset) begin
      chk("lookup_en", 32'(tlb_lookup_en), 32'(e_lookup));
      chk("update_en", 32'(tlb_update_en), 32'(e_maint && h.op == 2'd0));
      chk("inval_en", 32'(tlb_invalidate_en), 32'(e_maint && h.op == 2'd1));
      chk("inval_all_en", 32'(tlb_invalidate_all_en), 32'(e_maint && h.op == 2'd2));
      chk("lookup_stall", 32'(lookup_stall), 32'(lookup_req && e_maint));
      chk("lookup_valid", 32'(lookup_valid), 32'(m_lv));
      chk("cmd_done", 32'(cmd_done), 32'(m_done));
      chk("cmd_pending", 32'(cmd_pending), 32'((mq.size() > 0) || m_done));
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      if (e_lookup) begin
        chk("lk_vpage", 32'(tlb_request_vpage_idx), 32'(lookup_vpage_idx));
        chk("lk_asid", 32'(tlb_request_asid), 32'(lookup_asid));
      end
      if (e_maint && h.op <= 2'd1) begin
        chk("mt_vpage", 32'(tlb_request_vpage_idx), 32'(h.vp));
        chk("mt_asid", 32'(tlb_request_asid), 32'(h.asid));
      end
      if (e_maint && h.op == 2'd0) begin
        chk("mt_ppage", 32'(tlb_update_ppage_idx), 32'(h.pp));
        chk("mt_attr", 32'({tlb_update_present, tlb_update_exe_writable,
                            tlb_update_supervisor, tlb_update_global}), 32'(h.attr));
      end
    end
  end

  // Advance the model with the decisions made for the cycle just ended.
  always @(posedge clk) begin
    bit can_enq;
    if (reset) begin
      mq.delete();
      m_bubble = 0; m_wait = 0; m_lv = 0; m_done = 0;
    end else begin
      can_enq = (mq.size() < DEPTH);
      m_lv   = e_lookup;
      m_done = e_maint;
      if (e_maint) begin
        void'(mq.pop_front());
        m_wait = 0;
      end else if (e_iss && lookup_req && m_wait < MAXW) begin
        m_wait++;
      end
      m_bubble = e_maint;
      if (cmd_valid && can_enq)
        mq.push_back({cmd_op, cmd_vpage_idx, cmd_asid, cmd_ppage_idx,
                      {cmd_present, cmd_exe_writable, cmd_supervisor, cmd_global}});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input logic [PW-1:0] vp, input logic [PW-1:0] pp);
    cmd_valid        = v;
    cmd_op           = op;
    cmd_vpage_idx    = vp;
    cmd_ppage_idx    = pp;
    cmd_asid         = AW'($urandom);
    {cmd_present, cmd_exe_writable, cmd_supervisor, cmd_global} = 4'($urandom);
  endtask

  logic [7:0] pat_upd, pat_done, pat_pend;
  int found;
  int mode;

  initial begin
    // Reset values
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    settle;
    chk("rst_lookup_en", 32'(tlb_lookup_en), 32'd0);
    chk("rst_maint_en", 32'({tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pending_done", 32'({cmd_pending, cmd_done, lookup_valid, lookup_stall}), 32'd0);
    tick;

    // Idle lookup
    lookup_req = 1'b1; lookup_vpage_idx = 20'h12345; lookup_asid = 9'h011;
    for (int k = 0; k < 5; k++) begin
      settle;
      chk("idle_lookup_en", 32'(tlb_lookup_en), 32'd1);
      chk("idle_stall", 32'(lookup_stall), 32'd0);
      chk("idle_vpage", 32'(tlb_request_vpage_idx), 32'h12345);
      chk("idle_valid", 32'(lookup_valid), 32'(k > 0));
      tick;
    end
    lookup_req = 1'b0;
    settle; chk("idle_valid_last", 32'(lookup_valid), 32'd1); tick;
    settle; chk("idle_valid_off", 32'(lookup_valid), 32'd0); tick;

    // Update then lookup
    set_cmd(1'b1, 2'd0, 20'h00040, 20'h00777);
    settle; chk("upd_no_bypass", 32'(tlb_update_en), 32'd0); tick;
    cmd_valid = 1'b0;
    settle;
    chk("upd_issue", 32'(tlb_update_en), 32'd1);
    chk("upd_vpage", 32'(tlb_request_vpage_idx), 32'h00040);
    chk("upd_ppage", 32'(tlb_update_ppage_idx), 32'h00777);
    tick;
    lookup_req = 1'b1; lookup_vpage_idx = 20'h00040;
    settle;
    chk("upd_done", 32'(cmd_done), 32'd1);
    chk("upd_lookup_after", 32'(tlb_lookup_en), 32'd1);
    tick;
    lookup_req = 1'b0;
    settle; chk("upd_lookup_valid", 32'(lookup_valid), 32'd1); tick;

    // Bubble: three back-to-back updates
    pat_upd  = 8'b0010_1010;
    pat_done = 8'b0101_0100;
    pat_pend = 8'b0111_1110;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) set_cmd(1'b1, 2'd0, 20'(c + 1), 20'(c + 16'h100));
      else cmd_valid = 1'b0;
      settle;
      chk("bub_update_en", 32'(tlb_update_en), 32'(pat_upd[c]));
      chk("bub_done", 32'(cmd_done), 32'(pat_done[c]));
      chk("bub_pending", 32'(cmd_pending), 32'(pat_pend[c]));
      tick;
    end

    // Starvation
    lookup_req = 1'b1;
    set_cmd(1'b1, 2'd1, 20'h0abcd, 20'h0);
    settle; chk("stv_first_lookup", 32'(tlb_lookup_en), 32'd1); tick;
    cmd_valid = 1'b0;
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      settle;
      if (tlb_invalidate_en) begin
        found = k;
        chk("stv_stall", 32'(lookup_stall), 32'd1);
        chk("stv_no_lookup", 32'(tlb_lookup_en), 32'd0);
      end
      tick;
    end
    chk("stv_grants_before", 32'(found), 32'd9);
    settle;
    chk("stv_resume", 32'({tlb_lookup_en, lookup_stall}), 32'b10);
    tick;

    // Full queue under continuous lookups
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 4) set_cmd(1'b1, 2'(c % 2), 20'(c + 32), 20'(c + 64));
      else cmd_valid = 1'b0;
      settle;
      if (c == 4) chk("full_ready_low", 32'(cmd_ready), 32'd0);
      if (found != 0 && c == found + 1) chk("full_ready_back", 32'(cmd_ready), 32'd1);
      if (found == 0 && (tlb_update_en || tlb_invalidate_en)) found = c;
      tick;
    end
    chk("full_first_issue", 32'(found), 32'd9);
    lookup_req = 1'b0;
    repeat (10) tick;

    // Reset with two queued commands
    lookup_req = 1'b1;
    set_cmd(1'b1, 2'd0, 20'h1, 20'h2); tick;
    set_cmd(1'b1, 2'd1, 20'h3, 20'h4); tick;
    cmd_valid = 1'b0; reset = 1'b1; tick;
    reset = 1'b0; lookup_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      settle;
      chk("rst_no_maint", 32'({tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en, cmd_done}), 32'd0);
      if (k == 0) chk("rst_ready_pend", 32'({cmd_ready, cmd_pending}), 32'b10);
      tick;
    end

    // Reserved op
    set_cmd(1'b1, 2'd3, 20'h5, 20'h6); tick;
    cmd_valid = 1'b0;
    settle;
    chk("rsv_no_en", 32'({tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en}), 32'd0);
    chk("rsv_pending", 32'(cmd_pending), 32'd1);
    tick;
    settle; chk("rsv_done", 32'(cmd_done), 32'd1); tick;
    settle; chk("rsv_done_clear", 32'({cmd_done, cmd_pending}), 32'd0); tick;

    // Random traffic
    for (int c = 0; c < 2400; c++) begin
      mode = (c / 150) % 3;
      reset = ($urandom_range(0, 299) == 0);
      case (mode)
        0: lookup_req = ($urandom_range(0, 1) == 1);
        1: lookup_req = ($urandom_range(0, 9) != 0);
        default: lookup_req = ($urandom_range(0, 3) == 0);
      endcase
      lookup_vpage_idx = PW'($urandom);
      lookup_asid      = AW'($urandom);
      set_cmd($urandom_range(0, 2) == 0, 2'($urandom), PW'($urandom), PW'($urandom));
      tick;
    end
    reset = 1'b0; lookup_req = 1'b0; cmd_valid = 1'b0;
    repeat (3) tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
